// File: rtl/recirc_lane_ctrl_if.sv
// Handshake/bus bundle between the upstream striper, the recirculation
// controller and the 4-lane demux.
//   data_in/valid_in/ready_out : upstream word push (lane0=[7:0] .. lane3=[31:24])
//   mux_ready                  : mux path accepts a word this cycle
//   Out0..Out3/valid_out       : lane bytes and route select (1=mux, 0=probador)
// slave  = controller side, master = upstream/demux side (bench).
interface recirc_lane_ctrl_if;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic        mux_ready;
   logic [7:0]  Out0;
   logic [7:0]  Out1;
   logic [7:0]  Out2;
   logic [7:0]  Out3;
   logic        valid_out;

   modport slave (
      input  data_in, valid_in, mux_ready,
      output ready_out, Out0, Out1, Out2, Out3, valid_out
   );

   modport master (
      output data_in, valid_in, mux_ready,
      input  ready_out, Out0, Out1, Out2, Out3, valid_out
   );
endinterface

// File: rtl/recirc_lane_ctrl.sv
// Recirculation lane controller: buffers upstream words in a small FIFO,
// emits a SYNC preamble, then routes FIFO words to the mux path
// (valid_out=1) or recirculates the held head word to the probador
// (valid_out=0) while the mux path is stalled.
// Ports:
//   clk, reset_L    : clock, synchronous active-low reset
//   enable          : start/stop request from the link controller
//   bus             : data/handshake bundle (slave side)
//   state           : IDLE=0, SYNC=1, DATA=2, DRAIN=3
//   sent_cnt        : words delivered with valid_out=1 (saturating)
//   recirc_cnt      : cycles the head word was recirculated (saturating)
//   overflow        : sticky, push attempted while full outside DRAIN
module recirc_lane_ctrl #(
   parameter int         DEPTH    = 4,
   parameter int         SYNC_LEN = 2,
   parameter logic [7:0] COM_BYTE = 8'hBC
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                enable,
   recirc_lane_ctrl_if.slave   bus,
   output logic [1:0]          state,
   output logic [15:0]         sent_cnt,
   output logic [15:0]         recirc_cnt,
   output logic                overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN + 1) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

   state_t            state_q;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [SW-1:0]     sync_q;
   logic [3:0][7:0]   out_q;
   logic              vld_q;
   logic [15:0]       sent_q, recirc_q;
   logic              ovf_q;
   logic [31:0]       mem_q [DEPTH];

   logic              ready, push, pop, has_word;
   logic [31:0]       head;

   // Readiness uses the start-of-cycle count; a same-cycle pop does not
   // open a slot. Gating with reset_L keeps the FIFO untouched in reset.
   assign ready    = (count_q != CW'(DEPTH)) && (state_q != DRAIN) && reset_L;
   assign push     = bus.valid_in && ready;
   assign has_word = (count_q != '0);
   assign pop      = ((state_q == DATA) || (state_q == DRAIN)) && has_word && bus.mux_ready;
   assign head     = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sync_q   <= '0;
         out_q    <= '0;
         vld_q    <= 1'b0;
         sent_q   <= '0;
         recirc_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         // FIFO bookkeeping; pointers wrap naturally since DEPTH is 2^AW
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;

         if (bus.valid_in && !ready && (state_q != DRAIN)) ovf_q <= 1'b1;

         // Output registers default to idle; states override below
         out_q <= '0;
         vld_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= SYNC;
                  sync_q  <= '0;
               end
            end
            SYNC: begin
               if (!enable) begin
                  state_q <= IDLE;
               end else if (bus.mux_ready) begin
                  out_q  <= {4{COM_BYTE}};
                  vld_q  <= 1'b1;
                  sync_q <= sync_q + 1'b1;
                  if (sync_q == SW'(SYNC_LEN - 1)) state_q <= DATA;
               end
            end
            DATA, DRAIN: begin
               if (has_word) begin
                  // Head word is presented either way; mux_ready picks the route
                  out_q <= head;
                  if (bus.mux_ready) begin
                     vld_q <= 1'b1;
                     if (sent_q != 16'hFFFF) sent_q <= sent_q + 1'b1;
                  end else if (recirc_q != 16'hFFFF) begin
                     recirc_q <= recirc_q + 1'b1;
                  end
               end
               // DRAIN leaves only once the FIFO is seen empty, i.e. the
               // edge after the final pop
               if ((state_q == DATA) && !enable)      state_q <= DRAIN;
               else if ((state_q == DRAIN) && !has_word) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_out = ready;
   assign bus.Out0      = out_q[0];
   assign bus.Out1      = out_q[1];
   assign bus.Out2      = out_q[2];
   assign bus.Out3      = out_q[3];
   assign bus.valid_out = vld_q;
   assign state         = state_q;
   assign sent_cnt      = sent_q;
   assign recirc_cnt    = recirc_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_recirc_lane_ctrl.sv
module tb_recirc_lane_ctrl;
   localparam int         DEPTH    = 4;
   localparam int         SYNC_LEN = 2;
   localparam logic [7:0] COM      = 8'hBC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  state;
   logic [15:0] sent_cnt, recirc_cnt;
   logic        overflow;

   recirc_lane_ctrl_if bus();

   recirc_lane_ctrl #(.DEPTH(DEPTH), .SYNC_LEN(SYNC_LEN), .COM_BYTE(COM)) dut (
      .clk        (clk),
      .reset_L    (rst_n),
      .enable     (en),
      .bus        (bus),
      .state      (state),
      .sent_cnt   (sent_cnt),
      .recirc_cnt (recirc_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] q[$];
   int          m_state = 0;
   int          m_sync  = 0;
   logic [31:0] m_out   = '0;
   bit          m_vld   = 0;
   int          m_sent  = 0;
   int          m_recirc = 0;
   bit          m_ovf   = 0;
   bit          armed   = 0;
   int          pre;
   bit          rdy, popd;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_state = 0; m_sync = 0; m_out = '0; m_vld = 0;
         m_sent = 0; m_recirc = 0; m_ovf = 0;
      end else begin
         pre  = m_state;
         rdy  = (q.size() != DEPTH) && (pre != 3);
         popd = 0;
         m_out = '0;
         m_vld = 0;
         case (pre)
            0: if (en) begin m_state = 1; m_sync = 0; end
            1: begin
               if (!en) m_state = 0;
               else if (bus.mux_ready) begin
                  m_out = {4{COM}};
                  m_vld = 1;
                  m_sync++;
                  if (m_sync == SYNC_LEN) m_state = 2;
               end
            end
            default: begin
               if (q.size() > 0) begin
                  m_out = q[0];
                  if (bus.mux_ready) begin
                     m_vld = 1; popd = 1;
                     if (m_sent < 65535) m_sent++;
                  end else if (m_recirc < 65535) m_recirc++;
               end
               if (pre == 2 && !en) m_state = 3;
               else if (pre == 3 && q.size() == 0) m_state = 0;
            end
         endcase
         if (popd) void'(q.pop_front());
         if (bus.valid_in) begin
            if (rdy) q.push_back(bus.data_in);
            else if (pre != 3) m_ovf = 1;
         end
      end
      armed = 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (armed) begin
         chk("lanes",      {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, m_out);
         chk("valid_out",  32'(bus.valid_out), 32'(m_vld));
         chk("state",      32'(state), 32'(m_state));
         chk("sent_cnt",   32'(sent_cnt), 32'(m_sent));
         chk("recirc_cnt", 32'(recirc_cnt), 32'(m_recirc));
         chk("overflow",   32'(overflow), 32'(m_ovf));
         chk("ready_out",  32'(bus.ready_out),
             32'(rst_n && (q.size() != DEPTH) && (m_state != 3)));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   logic [31:0] w4 [5];

   initial begin
      w4[0] = 32'h13121110; w4[1] = 32'h23222120; w4[2] = 32'h33323130;
      w4[3] = 32'h43424140; w4[4] = 32'h53525150;
      rst_n = 0; en = 0; bus.data_in = '0; bus.valid_in = 0; bus.mux_ready = 0;
      tick(2);
      chk("rst state", 32'(state), 0);
      chk("rst valid", 32'(bus.valid_out), 0);
      chk("rst sent",  32'(sent_cnt), 0);
      rst_n = 1;

      // 1: SYNC preamble
      en = 1; bus.mux_ready = 1;
      tick(); chk("t1 state sync", 32'(state), 1);
      tick(); chk("t1 com0", 32'(bus.Out0), 32'hBC); chk("t1 vld", 32'(bus.valid_out), 1);
      tick(); chk("t1 com3", 32'(bus.Out3), 32'hBC); chk("t1 state data", 32'(state), 2);
      tick(); chk("t1 idle vld", 32'(bus.valid_out), 0); chk("t1 sent", 32'(sent_cnt), 0);

      // 2: single word, one-cycle latency
      bus.data_in = 32'hDDCCBBAA; bus.valid_in = 1;
      tick(); bus.valid_in = 0;
      chk("t2 not yet", 32'(bus.valid_out), 0);
      tick();
      chk("t2 out0", 32'(bus.Out0), 32'hAA); chk("t2 out3", 32'(bus.Out3), 32'hDD);
      chk("t2 vld", 32'(bus.valid_out), 1); chk("t2 sent", 32'(sent_cnt), 1);

      // 3: recirculate while stalled
      bus.mux_ready = 0; bus.data_in = 32'h44332211; bus.valid_in = 1;
      tick(); bus.valid_in = 0;
      tick(3);
      chk("t3 recirc", 32'(recirc_cnt), 3); chk("t3 out0", 32'(bus.Out0), 32'h11);
      chk("t3 out3", 32'(bus.Out3), 32'h44); chk("t3 vld", 32'(bus.valid_out), 0);
      bus.mux_ready = 1;
      tick(); chk("t3 deliver", 32'(bus.valid_out), 1); chk("t3 sent", 32'(sent_cnt), 2);
      tick();

      // 4: fill, overflow, ordered delivery
      bus.mux_ready = 0; bus.valid_in = 1;
      for (int i = 0; i < 5; i++) begin
         bus.data_in = w4[i];
         tick();
         if (i == 3) chk("t4 full ready", 32'(bus.ready_out), 0);
      end
      bus.valid_in = 0;
      chk("t4 overflow", 32'(overflow), 1);
      bus.mux_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4 order", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, w4[i]);
      end
      tick(); chk("t4 sent", 32'(sent_cnt), 6);

      // 5: drain on enable drop
      bus.mux_ready = 0; bus.valid_in = 1;
      for (int i = 0; i < 3; i++) begin bus.data_in = 32'h61 + 32'(i) * 32'h10; tick(); end
      bus.valid_in = 0; en = 0;
      tick(); chk("t5 drain", 32'(state), 3); chk("t5 ready", 32'(bus.ready_out), 0);
      bus.mux_ready = 1;
      tick(); chk("t5 w0", 32'(bus.Out0), 32'h61);
      tick(); chk("t5 w1", 32'(bus.Out0), 32'h71);
      tick(); chk("t5 w2", 32'(bus.Out0), 32'h81); chk("t5 still drain", 32'(state), 3);
      tick(); chk("t5 idle", 32'(state), 0); chk("t5 sent", 32'(sent_cnt), 9);

      // 6: reset mid-operation discards queued words
      en = 1; tick(3);
      bus.mux_ready = 0; bus.valid_in = 1;
      bus.data_in = 32'hCAFE0001; tick(); bus.data_in = 32'hCAFE0002; tick();
      bus.valid_in = 0; rst_n = 0;
      tick();
      chk("t6 state", 32'(state), 0); chk("t6 vld", 32'(bus.valid_out), 0);
      chk("t6 lanes", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 0);
      chk("t6 sent", 32'(sent_cnt), 0); chk("t6 recirc", 32'(recirc_cnt), 0);
      chk("t6 ovf", 32'(overflow), 0); chk("t6 ready", 32'(bus.ready_out), 0);
      rst_n = 1; bus.mux_ready = 1;
      tick(); tick(); chk("t6 resync", 32'(bus.Out0), 32'hBC);
      tick(); tick(); chk("t6 empty", 32'(bus.valid_out), 0); chk("t6 state data", 32'(state), 2);

      // 7: empty drain, SYNC abort, refused push in DRAIN
      en = 0; tick(); chk("t7 drain", 32'(state), 3);
      tick(); chk("t7 idle", 32'(state), 0);
      en = 1; tick(); bus.mux_ready = 0; tick();
      chk("t7 sync hold", 32'(bus.valid_out), 0); chk("t7 sync st", 32'(state), 1);
      en = 0; tick(); chk("t7 abort", 32'(state), 0);
      en = 1; bus.mux_ready = 1; tick(3);
      bus.mux_ready = 0; bus.data_in = 32'h0BADF00D; bus.valid_in = 1; tick();
      bus.valid_in = 0; en = 0; tick();
      bus.data_in = 32'hDEADBEEF; bus.valid_in = 1; tick();
      chk("t7 drain refuse ovf", 32'(overflow), 0); chk("t7 drain st", 32'(state), 3);
      bus.valid_in = 0; bus.mux_ready = 1;
      tick(); chk("t7 word", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 32'h0BADF00D);
      tick(); chk("t7 idle2", 32'(state), 0); chk("t7 sent", 32'(sent_cnt), 1);
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/recirc_lane_ctrl.md
Name: recirc_lane_ctrl

Overview:
Controller and sequencer for the 4-lane recirculation demux in phy_tx. It buffers 32-bit words from the upstream byte-striper in a small FIFO and emits a training (SYNC) preamble. It then drives the four 8-bit lanes plus the valid/route select consumed by the demux:
- valid_out=1 routes a word to the mux path.
- valid_out=0 with a held word recirculates that word to the probador.
It also keeps sent/recirculated word counters for the bench.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words (power of 2, >=2)
SYNC_LEN, 2, number of SYNC words emitted before data
COM_BYTE, 8'hBC, byte placed on all lanes during SYNC

Ports:
clk  in  1  single clock, all logic on posedge
reset_L  in  1  synchronous active-low reset
enable  in  1  start/stop request from the link controller
data_in  in  32  upstream word; lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24]
valid_in  in  1  upstream word valid
ready_out  out  1  upstream may push (combinational)
mux_ready  in  1  mux path accepts a word this cycle
Out0..Out3  out  8 each  registered lane bytes to the demux inputs
valid_out  out  1  registered route select to the demux (1=mux, 0=probador)
state  out  2  IDLE=0, SYNC=1, DATA=2, DRAIN=3
sent_cnt  out  16  data words delivered with valid_out=1, saturating
recirc_cnt  out  16  cycles a held word was presented with valid_out=0, saturating
overflow  out  1  sticky; set when a push is attempted while full

Behaviour:
- Reset: reset_L=0 sampled at a posedge clears the FIFO (count=0, pointers=0) and drives the following to 0 from the next cycle: state=IDLE, Out0..Out3, valid_out, sent_cnt, recirc_cnt, overflow.
- Reset mid-operation takes effect at the same edge. FIFO contents are discarded and no SYNC or data word is completed.
- ready_out = (count != DEPTH) && (state != DRAIN) && reset_L. It is based on the count at the start of the cycle, so a simultaneous pop does not free a slot the same cycle.
- Push: valid_in && ready_out writes data_in at the tail on the posedge.
- Overflow: valid_in && !ready_out in IDLE, SYNC or DATA drops the word and sets overflow. In DRAIN the push is silently refused.
- IDLE:
  - Outputs 0, valid_out=0.
  - enable=1 -> SYNC, with the sync counter cleared.
- SYNC:
  - Each cycle with mux_ready=1: registered outputs load COM_BYTE on all lanes with valid_out=1, and the sync counter increments.
  - mux_ready=0: outputs 0, valid_out=0, counter held.
  - After the SYNC_LEN-th emitted word -> DATA.
  - enable=0 during SYNC -> IDLE immediately; the partial preamble is abandoned.
  - SYNC words are not counted in sent_cnt.
- DATA, evaluated each cycle on the current count:
  - count>0 && mux_ready: pop the head into the output registers, valid_out=1, sent_cnt+1.
  - count>0 && !mux_ready: no pop; the head is loaded into the outputs with valid_out=0 (recirculated to probador), recirc_cnt+1.
  - count==0: outputs 0, valid_out=0, no counter change.
  - enable=0 -> DRAIN.
- DRAIN:
  - Same pop/recirculate rules as DATA; pushes are blocked.
  - When count reaches 0 -> IDLE; the state update occurs on the edge after the last pop.
  - enable=1 during DRAIN is ignored until IDLE is reached.
- Latency: a word written at edge E into an empty FIFO in DATA with mux_ready=1 appears on Out0..3 with valid_out=1 after edge E+1. Throughput is 1 word/cycle.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged. At count=DEPTH the push is refused.
- Pointers wrap modulo DEPTH.
- Counters saturate at 16'hFFFF; no wrap.
- The FIFO is the only storage of data_in. Output registers change only on the posedge.

Test Plan:
1. Reset, then enable=1 with mux_ready=1 -> state 0->1->2. Two cycles of Out0..3=8'hBC with valid_out=1, then valid_out=0 with outputs 0. sent_cnt=0.
2. In DATA, push 32'hDDCCBBAA with mux_ready=1 -> next cycle Out0=AA, Out1=BB, Out2=CC, Out3=DD, valid_out=1. sent_cnt=1.
3. Hold mux_ready=0 with 32'h44332211 queued for 3 cycles -> Out0..3=11,22,33,44 with valid_out=0 each cycle. recirc_cnt=3; the word is then delivered when mux_ready=1.
4. mux_ready=0, push 5 words with DEPTH=4 -> ready_out=0 after the 4th push, the 5th is dropped, overflow=1. The 4 words are delivered in order once mux_ready=1.
5. Drop enable with 3 words queued -> state=3, ready_out=0, 3 words delivered, then state=0.
6. Assert reset_L=0 for one cycle with 2 words queued in DATA -> next cycle all outputs, counters and overflow are 0, state=IDLE, and no queued word appears afterward.
